// File: rtl/console_ctrl_if.sv
// Byte-stream, clear-engine and VRAM write signals of the text console front end.
// slave is the console side, master is the upstream/testbench side.
interface console_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clr_start;
    logic       clr_line_mode;
    logic [4:0] clr_line_indx;
    logic       clr_busy;
    logic       clr_done;
    logic [15:0] waddr;
    logic [7:0] wdata;

    modport slave (
        input  in_valid, in_data, clr_busy, clr_done,
        output in_ready, clr_start, clr_line_mode, clr_line_indx, waddr, wdata
    );

    modport master (
        output in_valid, in_data, clr_busy, clr_done,
        input  in_ready, clr_start, clr_line_mode, clr_line_indx, waddr, wdata
    );
endinterface

// File: rtl/console_ctrl.sv
// Text console front end: decodes ASCII bytes, tracks the cursor, writes VRAM, requests clears.
// Define CONSOLE_AUTOCLR_EN to clear each new line on every row advance.
module console_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    console_ctrl_if.slave        bus_io,
    output logic [6:0]           cur_x_o,
    output logic [4:0]           cur_y_o
);

`ifdef CONSOLE_AUTOCLR_EN
    localparam bit AutoClr = 1'b1;
`else
    localparam bit AutoClr = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StClrWait} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [15:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        clr_start_q, clr_start_d;
    logic        clr_mode_q, clr_mode_d;
    logic [4:0]  clr_indx_q, clr_indx_d;

    logic       accept;
    logic       row_adv;
    logic [4:0] y_next;
    logic [7:0] data;

    assign bus_io.in_ready      = (state_q == StIdle) && !bus_io.clr_busy;
    assign accept               = bus_io.in_valid && bus_io.in_ready;
    assign data                 = bus_io.in_data;
    assign y_next               = (cur_y_q == 5'(ROWS - 1)) ? 5'd0 : cur_y_q + 5'd1;

    assign bus_io.waddr         = waddr_q;
    assign bus_io.wdata         = wdata_q;
    assign bus_io.clr_start     = clr_start_q;
    assign bus_io.clr_line_mode = clr_mode_q;
    assign bus_io.clr_line_indx = clr_indx_q;
    assign cur_x_o              = cur_x_q;
    assign cur_y_o              = cur_y_q;

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        waddr_d     = 16'h8000;
        wdata_d     = wdata_q;
        clr_start_d = 1'b0;
        clr_mode_d  = clr_mode_q;
        clr_indx_d  = clr_indx_q;
        row_adv     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (data >= 8'h20 && data <= 8'h7E) begin
                        waddr_d = {4'b0000, cur_y_q, cur_x_q};
                        wdata_d = data;
                        if (cur_x_q == 7'(COLS - 1)) begin
                            cur_x_d = 7'd0;
                            row_adv = 1'b1;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else begin
                        case (data)
                            8'h0A: begin
                                cur_x_d = 7'd0;
                                row_adv = 1'b1;
                            end
                            8'h0D: cur_x_d = 7'd0;
                            8'h08: begin
                                if (cur_x_q != 7'd0) begin
                                    cur_x_d = cur_x_q - 7'd1;
                                    waddr_d = {4'b0000, cur_y_q, cur_x_q - 7'd1};
                                    wdata_d = 8'h20;
                                end
                            end
                            8'h0C: begin
                                cur_x_d     = 7'd0;
                                cur_y_d     = 5'd0;
                                clr_start_d = 1'b1;
                                clr_mode_d  = 1'b0;
                                state_d     = StClrWait;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StClrWait: begin
                // Exit on done only; busy may already be low before done arrives.
                if (bus_io.clr_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // No scrolling: the cursor wraps to the top row.
        if (row_adv) begin
            cur_y_d = y_next;
            if (AutoClr) begin
                clr_start_d = 1'b1;
                clr_mode_d  = 1'b1;
                clr_indx_d  = y_next;
                state_d     = StClrWait;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_x_q     <= 7'd0;
            cur_y_q     <= 5'd0;
            waddr_q     <= 16'h8000;
            wdata_q     <= 8'h20;
            clr_start_q <= 1'b0;
            clr_mode_q  <= 1'b0;
            clr_indx_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            clr_start_q <= clr_start_d;
            clr_mode_q  <= clr_mode_d;
            clr_indx_q  <= clr_indx_d;
        end
    end

endmodule

// File: tb/tb_console_ctrl.sv
// Directed self-checking bench for console_ctrl; expectations follow CONSOLE_AUTOCLR_EN.
module tb_console_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cur_x;
    logic [4:0] cur_y;
    int         checks = 0;
    int         errors = 0;
    logic       ok;

    console_ctrl_if bus ();

    console_ctrl #(.COLS(80), .ROWS(30)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_io  (bus),
        .cur_x_o (cur_x),
        .cur_y_o (cur_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic serve();
        if (!bus.in_ready) begin
            bus.clr_done = 1'b1;
            @(negedge clk);
            bus.clr_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.clr_busy = 1'b0;
        bus.clr_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_waddr", bus.waddr, 32'h8000);
        chk("rst_wdata", bus.wdata, 32'h20);
        chk("rst_clr_start", bus.clr_start, 0);
        chk("rst_line_mode", bus.clr_line_mode, 0);
        chk("rst_line_indx", bus.clr_line_indx, 0);
        chk("rst_cur_x", cur_x, 0);
        chk("rst_cur_y", cur_y, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        send(8'h41);
        chk("a_waddr", bus.waddr, 32'h0000);
        chk("a_wdata", bus.wdata, 32'h41);
        chk("a_cur_x", cur_x, 1);
        @(negedge clk);
        chk("a_waddr_idle", bus.waddr, 32'h8000);
        chk("a_cur_x_hold", cur_x, 1);

        send(8'h0D);
        chk("cr_cur_x", cur_x, 0);
        chk("cr_nowrite", bus.waddr, 32'h8000);

        // 80 printables back to back with valid held high.
        for (int i = 0; i < 80; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h42;
            @(posedge clk);
            @(negedge clk);
            chk("burst_addr", bus.waddr, i);
        end
        bus.in_valid = 1'b0;
        chk("burst_wdata", bus.wdata, 32'h42);
        chk("burst_cur_x", cur_x, 0);
        chk("burst_cur_y", cur_y, 1);
`ifdef CONSOLE_AUTOCLR_EN
        chk("burst_clr_start", bus.clr_start, 1);
        chk("burst_line_mode", bus.clr_line_mode, 1);
        chk("burst_line_indx", bus.clr_line_indx, 1);
        chk("burst_ready_low", bus.in_ready, 0);
        @(negedge clk);
        chk("burst_start_pulse", bus.clr_start, 0);
        chk("burst_ready_wait", bus.in_ready, 0);
        serve();
`else
        chk("burst_no_clr", bus.clr_start, 0);
        chk("burst_ready_high", bus.in_ready, 1);
`endif
        chk("burst_ready_after", bus.in_ready, 1);

        for (int i = 0; i < 28; i++) begin
            send(8'h0A);
            serve();
        end
        for (int i = 0; i < 5; i++) send(8'h78);
        chk("pos_cur_x", cur_x, 5);
        chk("pos_cur_y", cur_y, 29);
        send(8'h0A);
        chk("wrap_cur_y", cur_y, 0);
        chk("wrap_cur_x", cur_x, 0);
        chk("wrap_nowrite", bus.waddr, 32'h8000);
`ifdef CONSOLE_AUTOCLR_EN
        chk("wrap_clr_start", bus.clr_start, 1);
        chk("wrap_line_mode", bus.clr_line_mode, 1);
        chk("wrap_line_indx", bus.clr_line_indx, 0);
        chk("wrap_ready_low", bus.in_ready, 0);
`else
        chk("wrap_no_clr", bus.clr_start, 0);
        chk("wrap_ready_high", bus.in_ready, 1);
`endif
        serve();

        for (int i = 0; i < 7; i++) begin
            send(8'h0A);
            serve();
        end
        for (int i = 0; i < 10; i++) send(8'h79);
        chk("ff_pre_x", cur_x, 10);
        chk("ff_pre_y", cur_y, 7);
        send(8'h0C);
        chk("ff_clr_start", bus.clr_start, 1);
        chk("ff_line_mode", bus.clr_line_mode, 0);
        chk("ff_cur_x", cur_x, 0);
        chk("ff_cur_y", cur_y, 0);
        chk("ff_ready_low", bus.in_ready, 0);
        bus.clr_busy = 1'b1;
        @(negedge clk);
        chk("ff_start_pulse", bus.clr_start, 0);
        ok = 1'b1;
        repeat (2398) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ok = 1'b0;
        end
        chk("ff_ready_low_whole_clear", {31'd0, ok}, 1);
        bus.clr_busy = 1'b0;
        bus.clr_done = 1'b1;
        #1;
        chk("ff_ready_low_at_done", bus.in_ready, 0);
        @(negedge clk);
        bus.clr_done = 1'b0;
        #1;
        chk("ff_ready_after_done", bus.in_ready, 1);
        @(negedge clk);

        bus.clr_done = 1'b1;
        @(negedge clk);
        bus.clr_done = 1'b0;
        chk("idle_done_ignored", bus.in_ready, 1);
        bus.clr_busy = 1'b1;
        #1;
        chk("idle_busy_blocks", bus.in_ready, 0);
        bus.clr_busy = 1'b0;
        #1;
        chk("idle_busy_release", bus.in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            send(8'h0A);
            serve();
        end
        for (int i = 0; i < 3; i++) send(8'h7A);
        send(8'h08);
        chk("bs_waddr", bus.waddr, 32'h0102);
        chk("bs_wdata", bus.wdata, 32'h20);
        chk("bs_cur_x", cur_x, 2);
        chk("bs_cur_y", cur_y, 2);
        send(8'h0D);
        send(8'h08);
        chk("bs0_nowrite", bus.waddr, 32'h8000);
        chk("bs0_cur_x", cur_x, 0);
        chk("bs0_cur_y", cur_y, 2);
        send(8'h07);
        chk("bel_nowrite", bus.waddr, 32'h8000);
        chk("bel_cur_x", cur_x, 0);
        chk("bel_cur_y", cur_y, 2);
        send(8'h7E);
        chk("tilde_waddr", bus.waddr, 32'h0100);
        chk("tilde_wdata", bus.wdata, 32'h7E);
        chk("tilde_cur_x", cur_x, 1);
        send(8'h7F);
        chk("del_nowrite", bus.waddr, 32'h8000);
        chk("del_cur_x", cur_x, 1);
        send(8'h1F);
        chk("us_nowrite", bus.waddr, 32'h8000);
        chk("us_cur_x", cur_x, 1);

        send(8'h0C);
        bus.clr_busy = 1'b1;
        @(negedge clk);
        chk("mid_ready_low", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_waddr", bus.waddr, 32'h8000);
        chk("mid_rst_wdata", bus.wdata, 32'h20);
        chk("mid_rst_clr_start", bus.clr_start, 0);
        chk("mid_rst_line_mode", bus.clr_line_mode, 0);
        chk("mid_rst_line_indx", bus.clr_line_indx, 0);
        chk("mid_rst_cur_x", cur_x, 0);
        chk("mid_rst_cur_y", cur_y, 0);
        chk("mid_rst_ready_busy", bus.in_ready, 0);
        bus.clr_busy = 1'b0;
        #1;
        chk("mid_rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
